// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, picks jr/jump/branch/sequential next PC, and drives the fetch handshake.
// Optional misaligned-jr trap enabled by PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        halt,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        redirect,
  output logic        trap,
  output logic [15:0] taken_count
);

`ifdef PC_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HALTED, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HALTED} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic        redirect_nxt;
  logic        accept;
  logic        misalign_jr;

`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q, trap_nxt;
  assign misalign_jr = (jr_addr[1:0] != 2'b00);
  assign trap        = trap_q;
`else
  assign misalign_jr = 1'b0;
  assign trap        = 1'b0;
`endif

  assign pc_plus4    = pc + 32'd4;
  assign fetch_valid = (state == S_FETCH);
  assign accept      = (state == S_FETCH) && fetch_ready && !stall && !halt;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    redirect_nxt = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    trap_nxt     = 1'b0;
`endif

    case (state)
      S_BOOT:   state_nxt = S_FETCH;
      S_FETCH:  if (halt) state_nxt = S_HALTED;
`ifdef PC_MISALIGN_TRAP_EN
      S_TRAP:   state_nxt = S_FETCH;
`endif
      default:  state_nxt = state;
    endcase

    // Priority: jr > jump > taken branch > sequential.
    if (accept) begin
      if (jr) begin
        if (misalign_jr) begin
          pc_nxt = TRAP_PC;
`ifdef PC_MISALIGN_TRAP_EN
          state_nxt = S_TRAP;
          trap_nxt  = 1'b1;
`endif
        end else begin
          pc_nxt       = jr_addr & 32'hFFFF_FFFC;
          redirect_nxt = 1'b1;
        end
      end else if (jump) begin
        pc_nxt       = {pc_plus4[31:28], jump_index, 2'b00};
        redirect_nxt = 1'b1;
      end else if (branch && zero) begin
        pc_nxt       = pc_plus4 + branch_offset;
        redirect_nxt = 1'b1;
      end else begin
        pc_nxt = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      redirect    <= 1'b0;
      taken_count <= 16'd0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      redirect <= redirect_nxt;
      if (redirect_nxt && (taken_count != 16'hFFFF))
        taken_count <= taken_count + 16'd1;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= trap_nxt;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed steps plus randomized traffic against a behavioural PC model.
module tb_pc_sequencer;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [31:0] R_PC = 32'h0000_0000;
  localparam logic [31:0] T_PC = 32'h0000_0080;
  localparam int M_BOOT = 0, M_FETCH = 1, M_HALTED = 2, M_TRAP = 3;

  logic        clk = 1'b0;
  logic        rst_n, fetch_ready, stall, halt, branch, zero, jump, jr;
  logic [31:0] branch_offset, jr_addr;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, redirect, trap;
  logic [15:0] taken_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  int          m_mode;
  logic        m_red, m_trap;
  int          m_cnt;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .stall(stall), .halt(halt),
    .branch(branch), .zero(zero), .branch_offset(branch_offset), .jump(jump),
    .jump_index(jump_index), .jr(jr), .jr_addr(jr_addr), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .redirect(redirect), .trap(trap), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what one rising edge does given the inputs currently applied.
  task automatic model_edge();
    logic [31:0] p4;
    bit acc;
    if (!rst_n) begin
      m_pc = R_PC; m_mode = M_BOOT; m_red = 0; m_trap = 0; m_cnt = 0;
      return;
    end
    acc = (m_mode == M_FETCH) && fetch_ready && !stall && !halt;
    p4 = m_pc + 32'd4;
    m_red = 0; m_trap = 0;
    if (m_mode == M_BOOT || m_mode == M_TRAP) m_mode = M_FETCH;
    else if (m_mode == M_FETCH && halt) m_mode = M_HALTED;
    if (acc) begin
      if (jr) begin
        if (TRAP_EN && (jr_addr % 4 != 0)) begin
          m_pc = T_PC; m_trap = 1; m_mode = M_TRAP;
        end else begin
          m_pc = jr_addr - (jr_addr % 4); m_red = 1;
        end
      end else if (jump) begin
        m_pc = (p4 & 32'hF000_0000) | (32'(jump_index) * 4); m_red = 1;
      end else if (branch && zero) begin
        m_pc = p4 + branch_offset; m_red = 1;
      end else begin
        m_pc = p4;
      end
      if (m_red && m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_mode == M_FETCH});
    check("redirect", {31'd0, redirect}, {31'd0, m_red});
    check("trap", {31'd0, trap}, {31'd0, m_trap});
    check("taken_count", {16'd0, taken_count}, m_cnt[31:0]);
  endtask

  task automatic step(input bit chk);
    model_edge();
    @(posedge clk);
    #1;
    if (chk) compare_all();
  endtask

  task automatic clr_sel();
    branch = 0; zero = 0; branch_offset = 0; jump = 0; jump_index = 0; jr = 0; jr_addr = 0;
  endtask

  task automatic go_jr(input logic [31:0] a);
    clr_sel(); jr = 1; jr_addr = a; step(1); clr_sel();
  endtask

  initial begin
    rst_n = 0; fetch_ready = 1; stall = 0; halt = 0; clr_sel();
    // Reset / boot
    for (int i = 0; i < 3; i++) step(1);
    check("rst_pc", pc, 32'h0);
    rst_n = 1; #1;
    compare_all();
    check("boot_fv0", {31'd0, fetch_valid}, 32'd0);
    step(1);
    check("boot_fv1", {31'd0, fetch_valid}, 32'd1);
    step(1); step(1);
    check("seq_pc8", pc, 32'h8);
    // Handshake: fetch_ready low 4 cycles, then stall 2 cycles
    fetch_ready = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("hold_rdy", pc, 32'h8);
    end
    fetch_ready = 1; stall = 1;
    for (int i = 0; i < 2; i++) step(1);
    check("hold_stall", pc, 32'h8);
    stall = 0; step(1);
    check("adv_c", pc, 32'hC);
    // Walk sequentially to 0x40 with no redirects yet
    for (int i = 0; i < 32 && m_pc != 32'h40; i++) step(1);
    check("walk_40", pc, 32'h40);
    // Branch taken / not taken
    branch = 1; zero = 1; branch_offset = 32'hFFFF_FFF0; step(1);
    check("br_taken_pc", pc, 32'h34);
    check("br_taken_red", {31'd0, redirect}, 32'd1);
    check("br_taken_cnt", {16'd0, taken_count}, 32'd1);
    go_jr(32'h40);
    branch = 1; zero = 0; branch_offset = 32'hFFFF_FFF0; step(1);
    check("br_nt_pc", pc, 32'h44);
    check("br_nt_red", {31'd0, redirect}, 32'd0);
    // Priority
    go_jr(32'h1000_0010);
    jump = 1; jump_index = 26'h000_0100; branch = 1; zero = 1; branch_offset = 32'h40; step(1);
    check("jump_pc", pc, 32'h1000_0400);
    clr_sel(); go_jr(32'h1000_0010);
    jump = 1; jump_index = 26'h000_0100; branch = 1; zero = 1; jr = 1; jr_addr = 32'h200; step(1);
    check("jr_prio_pc", pc, 32'h200);
    // Misaligned jr
    go_jr(32'h0000_0103);
    check("mis_pc", pc, TRAP_EN ? 32'h80 : 32'h100);
    check("mis_trap", {31'd0, trap}, {31'd0, TRAP_EN});
    check("mis_fv", {31'd0, fetch_valid}, {31'd0, !TRAP_EN});
    step(1);
    check("mis_after_trap", {31'd0, trap}, 32'd0);
    // Wrap
    go_jr(32'hFFFF_FFFC);
    step(1);
    check("wrap_pc", pc, 32'h0);
    // Randomized traffic with occasional reset and halt
    for (int i = 0; i < 400; i++) begin
      rst_n         = ($urandom_range(0, 39) != 0);
      fetch_ready   = ($urandom_range(0, 3) != 0);
      stall         = ($urandom_range(0, 4) == 0);
      halt          = ($urandom_range(0, 59) == 0);
      jr            = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 7) == 0);
      branch        = ($urandom_range(0, 2) == 0);
      zero          = $urandom_range(0, 1) == 1;
      branch_offset = 32'($signed($urandom_range(0, 255)) - 128) << 2;
      jump_index    = 26'($urandom);
      jr_addr       = $urandom;
      step(1);
    end
    // Halt freezes until reset
    rst_n = 0; fetch_ready = 1; stall = 0; halt = 0; clr_sel(); step(1);
    rst_n = 1; step(1); step(1); step(1);
    halt = 1; step(1);
    check("halt_fv", {31'd0, fetch_valid}, 32'd0);
    halt = 0; jr = 1; jr_addr = 32'h300;
    for (int i = 0; i < 3; i++) step(1);
    check("halt_pc", pc, 32'h8);
    clr_sel();
    // Saturation: a taken branch with offset -4 re-fetches the same pc
    rst_n = 0; step(1); rst_n = 1; step(1);
    branch = 1; zero = 1; branch_offset = 32'hFFFF_FFFC;
    for (int i = 0; i < 65534; i++) step(0);
    compare_all();
    check("cnt_fffe", {16'd0, taken_count}, 32'hFFFE);
    step(1);
    check("cnt_ffff", {16'd0, taken_count}, 32'hFFFF);
    step(1);
    check("cnt_sat", {16'd0, taken_count}, 32'hFFFF);
    clr_sel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter sequencer for the single-cycle datapath. It holds the PC and computes PC+4. It selects the next PC from sequential, branch, jump and jump-register sources, using the byte-aligned branch offset produced by the branch shift-left-2 unit. It runs a valid/ready fetch handshake toward instruction memory.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_PC, 32'h0000_0080, PC loaded on a misaligned jump-register target. Used only when PC_MISALIGN_TRAP_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- fetch_ready  in  1  instruction memory accepts the current pc.
- stall  in  1  hazard hold; blocks PC advance.
- halt  in  1  stop fetching until reset.
- branch  in  1  branch instruction in flight.
- zero  in  1  ALU zero flag; a branch is taken when branch && zero.
- branch_offset  in  32  sign-extended byte offset, already shifted left by 2.
- jump  in  1  J-type jump.
- jump_index  in  26  J-type target field.
- jr  in  1  jump register.
- jr_addr  in  32  register target for jr.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4, combinational from pc.
- fetch_valid  out  1  pc is valid for fetch.
- redirect  out  1  one-cycle pulse after a non-sequential update.
- trap  out  1  one-cycle pulse after a misaligned-jr trap; tied 0 without the macro.
- taken_count  out  16  saturating count of taken redirects.

## Operation
- States:
  - BOOT: fetch_valid=0.
  - FETCH: fetch_valid=1.
  - TRAP: fetch_valid=0. Exists only with the macro.
  - HALTED: fetch_valid=0.
- Transitions:
  - Reset enters BOOT. BOOT goes to FETCH after 1 cycle.
  - In FETCH, halt=1 goes to HALTED. halt has priority over accept, and the pc is not updated.
  - HALTED is left only by reset.
  - TRAP goes to FETCH after 1 cycle.
- Accept: state==FETCH && fetch_ready && !stall && !halt. The PC changes only on accept. Otherwise pc and fetch_valid hold, with no combinational dependence on fetch_ready.
- Next-PC priority on accept:
  - jr: jr_addr.
  - jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - branch && zero: pc_plus4 + branch_offset.
  - otherwise: pc_plus4.
- Arithmetic: all sums are 32-bit modulo 2^32. Wrap is silent, e.g. 32'hFFFF_FFFC + 4 = 0.
- If several select signals are asserted together, the priority above applies and no error is flagged.
- redirect: registered. It is 1 in the cycle after an accept that selected jr, jump or taken branch, and 0 otherwise.
- taken_count: increments on each accept that asserts redirect. It saturates at 16'hFFFF.
- Reset mid-operation:
  - pc=RESET_PC; state BOOT.
  - redirect=0, trap=0, taken_count=0.
  - Any pending selects are ignored.

## Timing
- Reset values: pc=RESET_PC, pc_plus4=RESET_PC+4, fetch_valid=0, redirect=0, trap=0, taken_count=0.
- First fetch_valid=1 occurs in the 2nd cycle after rst_n rises: BOOT lasts 1 cycle.
- Update latency is 1 cycle: the new pc is visible the cycle after the accept edge. Back-to-back accepts sustain 1 PC per cycle.
- Select inputs (branch, zero, branch_offset, jump, jump_index, jr, jr_addr) are sampled only on the accept edge.
- A stall or fetch_ready=0 for N cycles holds pc for exactly N cycles.

## Configuration
- Macro: PC_MISALIGN_TRAP_EN.
- Defined: on an accept selecting jr with jr_addr[1:0]!=0:
  - pc<=TRAP_PC.
  - State enters TRAP, so fetch_valid=0 for 1 cycle.
  - trap=1 for that cycle. redirect=0, and taken_count is unchanged.
- Not defined:
  - A jr target is used as {jr_addr[31:2], 2'b00}.
  - No TRAP state exists, and trap is constant 0.

## Test plan
- Reset/boot: hold rst_n=0 for 3 cycles, then release, with fetch_ready=1.
  - Cycle 1: pc=0, fetch_valid=0.
  - Cycle 2: fetch_valid=1.
  - Then pc steps 0 → 4 → 8 → 12.
- Branch: pc=32'h40, branch=1, zero=1, branch_offset=32'hFFFF_FFF0 → next pc=32'h34, redirect=1, taken_count=1. The same stimulus with zero=0 → pc=32'h44, redirect=0.
- Priority/jump: pc=32'h1000_0010, jump=1, jump_index=26'h000_0100, branch=1, zero=1 → pc=32'h1000_0400. With jr=1 and jr_addr=32'h200 also asserted → pc=32'h200.
- Handshake: fetch_ready=0 for 4 cycles at pc=32'h8 → pc stays 32'h8 with fetch_valid=1 held. Repeat with stall=1 for 2 cycles → pc holds 2 cycles and then advances to 32'hC.
- Misaligned jr: jr_addr=32'h0000_0103.
  - With PC_MISALIGN_TRAP_EN: pc=32'h80, trap=1 for 1 cycle, fetch_valid=0 for 1 cycle.
  - Without the macro: pc=32'h100, trap=0.
- Halt/wrap/saturation:
  - pc=32'hFFFF_FFFC with an accept → pc=0.
  - halt=1 → fetch_valid=0 and pc frozen until reset.
  - Preload 65535 taken branches, then 1 more taken branch → taken_count stays 16'hFFFF.
